// File: rtl/melody_pkg.sv
// Shared types and constants for the melody player: note fields, pitch table, FSM states.
package melody_pkg;

    localparam int PITCH_W = 4;
    localparam int DUR_W   = 4;
    localparam int NOTE_W  = PITCH_W + DUR_W;
    localparam int TONE_W  = 17;

    localparam logic [NOTE_W-1:0] END_MARKER = 8'h00;

    // Half-periods at 50 MHz for C4 D4 E4 F4 G4 A4 B4 C5 (pitch codes 1..8)
    localparam logic [TONE_W-1:0] HALF_PERIOD [8] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic is_tone(input logic [PITCH_W-1:0] p);
        return (p != 4'd0) && (p <= 4'd8);
    endfunction

    function automatic logic [TONE_W-1:0] eff_half(input logic [PITCH_W-1:0] p, input int shift);
        logic [TONE_W-1:0] h;
        logic [2:0]        idx;
        idx = p[2:0] - 3'd1;
        h   = HALF_PERIOD[idx] >> shift;
        if (!is_tone(p) || (h == 17'd0)) begin
            h = 17'd1;
        end else begin
            h = h;
        end
        return h;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Per-song note ROM with a registered (one-cycle latency) read; unused entries hold the end marker.
module melody_rom
    import melody_pkg::*;
#(
    parameter int SONG_ID  = 0,
    parameter int SONG_LEN = 32,
    parameter int AW       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic [AW-1:0]     addr,
    output logic [NOTE_W-1:0] data
);

    logic [NOTE_W-1:0] data_r;
    logic [NOTE_W-1:0] word_s;
    logic [31:0]       idx_s;

    // Song contents lookup
    always_comb begin
        idx_s  = 32'(addr);
        word_s = END_MARKER;
        case (SONG_ID)
            32'sd0: begin
                case (idx_s)
                    32'd0:   word_s = 8'h62;
                    default: word_s = END_MARKER;
                endcase
            end
            32'sd1: begin
                case (idx_s)
                    32'd0:   word_s = 8'h11;
                    32'd1:   word_s = 8'h01;
                    32'd2:   word_s = 8'h81;
                    default: word_s = END_MARKER;
                endcase
            end
            32'sd2: begin
                case (idx_s)
                    32'd0:   word_s = 8'h11;
                    32'd1:   word_s = 8'h81;
                    32'd2:   word_s = 8'h31;
                    32'd3:   word_s = 8'h51;
                    default: word_s = END_MARKER;
                endcase
            end
            default: word_s = END_MARKER;
        endcase
    end

    // Registered read port
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= END_MARKER;
        end else begin
            data_r <= word_s;
        end
    end

    assign data = data_r;

endmodule

// File: rtl/melody_player.sv
// Single-song buzzer player: fetches notes from melody_rom, plays each as a square wave
// for its duration, then a silent gap. buzzer_out is 0 whenever no note is sounding.
module melody_player
    import melody_pkg::*;
#(
    parameter int SONG_ID     = 0,
    parameter int SONG_LEN    = 32,
    parameter int UNIT_CYCLES = 6_250_000,
    parameter int GAP_CYCLES  = 625_000,
    parameter int TONE_SHIFT  = 0
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    output logic buzzer_out,
    output logic busy,
    output logic done
);

    localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(SONG_LEN - 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_t               state_r, state_nxt_s;
    logic [AW-1:0]        addr_r, addr_nxt_s;
    logic [PITCH_W-1:0]   pitch_r, pitch_nxt_s;
    logic [DUR_W-1:0]     units_r, units_nxt_s;
    logic [UW-1:0]        unit_cnt_r, unit_cnt_nxt_s;
    logic [TONE_W-1:0]    tone_cnt_r, tone_cnt_nxt_s;
    logic [GW-1:0]        gap_cnt_r, gap_cnt_nxt_s;
    logic                 buzz_r, buzz_nxt_s;
    logic                 busy_r, done_r;
    logic [NOTE_W-1:0]    rom_word_s;
    logic [TONE_W-1:0]    half_last_s;

    // ROM is addressed with the next address so the word is ready during LOAD
    melody_rom #(
        .SONG_ID  (SONG_ID),
        .SONG_LEN (SONG_LEN),
        .AW       (AW)
    ) u_rom (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .addr     (addr_nxt_s),
        .data     (rom_word_s)
    );

    assign half_last_s = eff_half(pitch_r, TONE_SHIFT) - 17'd1;

    // Next-state and next-counter logic
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        pitch_nxt_s    = pitch_r;
        units_nxt_s    = units_r;
        unit_cnt_nxt_s = unit_cnt_r;
        tone_cnt_nxt_s = tone_cnt_r;
        gap_cnt_nxt_s  = gap_cnt_r;
        buzz_nxt_s     = buzz_r;
        if (stop) begin
            state_nxt_s    = IDLE;
            addr_nxt_s     = '0;
            pitch_nxt_s    = '0;
            units_nxt_s    = '0;
            unit_cnt_nxt_s = '0;
            tone_cnt_nxt_s = '0;
            gap_cnt_nxt_s  = '0;
            buzz_nxt_s     = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nxt_s = LOAD;
                        addr_nxt_s  = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LOAD: begin
                    if (rom_word_s[DUR_W-1:0] == 4'd0) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s    = PLAY;
                        pitch_nxt_s    = rom_word_s[NOTE_W-1:DUR_W];
                        units_nxt_s    = rom_word_s[DUR_W-1:0];
                        unit_cnt_nxt_s = '0;
                        tone_cnt_nxt_s = '0;
                        buzz_nxt_s     = is_tone(rom_word_s[NOTE_W-1:DUR_W]);
                    end
                end
                PLAY: begin
                    if (tone_cnt_r == half_last_s) begin
                        tone_cnt_nxt_s = '0;
                        buzz_nxt_s     = is_tone(pitch_r) ? ~buzz_r : 1'b0;
                    end else begin
                        tone_cnt_nxt_s = tone_cnt_r + 1'b1;
                    end
                    // Unit boundary: either count down remaining units or end the note
                    if (unit_cnt_r == UNIT_LAST) begin
                        unit_cnt_nxt_s = '0;
                        if (units_r == 4'd1) begin
                            state_nxt_s    = GAP;
                            units_nxt_s    = '0;
                            tone_cnt_nxt_s = '0;
                            gap_cnt_nxt_s  = '0;
                            buzz_nxt_s     = 1'b0;
                        end else begin
                            units_nxt_s = units_r - 4'd1;
                        end
                    end else begin
                        unit_cnt_nxt_s = unit_cnt_r + 1'b1;
                    end
                end
                GAP: begin
                    buzz_nxt_s = 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_nxt_s = '0;
                        if (addr_r == ADDR_LAST) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = LOAD;
                            addr_nxt_s  = addr_r + 1'b1;
                        end
                    end else begin
                        gap_cnt_nxt_s = gap_cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s    = IDLE;
                    addr_nxt_s     = '0;
                    unit_cnt_nxt_s = '0;
                    tone_cnt_nxt_s = '0;
                    gap_cnt_nxt_s  = '0;
                    buzz_nxt_s     = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            pitch_r    <= '0;
            units_r    <= '0;
            unit_cnt_r <= '0;
            tone_cnt_r <= '0;
            gap_cnt_r  <= '0;
            buzz_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            pitch_r    <= pitch_nxt_s;
            units_r    <= units_nxt_s;
            unit_cnt_r <= unit_cnt_nxt_s;
            tone_cnt_r <= tone_cnt_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            buzz_r     <= buzz_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (state_nxt_s == DONE);
        end
    end

    assign buzzer_out = buzz_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/melody_player.md
# melody_player

Plays a fixed melody on a single buzzer line: on `start`, fetches notes (pitch, duration) from a note ROM and drives a square wave at the note's pitch for the note's duration, separated by short silent gaps. One instance exists per song; each instance's `buzzer_out` feeds one input of the board-level buzzer OR-combiner. For that reason `buzzer_out` must be 0 whenever the instance is not sounding a note.

## Interface
Parameters:
- `SONG_ID`, 0: selects the melody contents in `melody_rom` (0..2).
- `SONG_LEN`, 32: ROM depth in notes; address width is clog2(SONG_LEN).
- `UNIT_CYCLES`, 6_250_000: clocks per duration unit (125 ms at 50 MHz).
- `GAP_CYCLES`, 625_000: silent clocks after every note.
- `TONE_SHIFT`, 0: right-shift applied to table half-periods; used only to shorten simulation.

Ports:
- `clock_in`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to play from note 0; ignored while `busy`.
- `stop`  in  1  abort playback; has priority over everything except reset.
- `buzzer_out`  out  1  registered square wave; 0 when idle, resting or in a gap.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on natural end of song (not on `stop`).

## Operation
- Note word is 8 bits: [7:4] pitch, [3:0] duration units.
- Pitch 0 and pitches 9..15 are rests: the note is timed normally and `buzzer_out` is held 0.
- Pitches 1..8 map to C4 D4 E4 F4 G4 A4 B4 C5. The half-periods at 50 MHz are 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778.
- Effective half-period H = max(table >> TONE_SHIFT, 1).
- Duration 0 is the end-of-song marker.
- States:
  - IDLE: on `start`, set addr=0 and go to LOAD.
  - LOAD: one cycle for the synchronous ROM read. Next cycle, evaluate the word: if duration = 0, go to DONE; otherwise latch pitch and duration and go to PLAY.
  - PLAY: run the tone counter and the unit counter. After duration × UNIT_CYCLES clocks, go to GAP.
  - GAP: `buzzer_out` = 0 for GAP_CYCLES clocks. Then, if addr = SONG_LEN−1, go to DONE; otherwise increment addr and go to LOAD.
  - DONE: `done` = 1 for one cycle, then go to IDLE.
- `stop` in any non-IDLE state: next state is IDLE, `buzzer_out` = 0, counters cleared, no `done`.
- `start` and `stop` in the same IDLE cycle: `stop` wins and the block stays in IDLE.
- Tone counter: counts 0..H−1. At H−1 it toggles `buzzer_out` and reloads to 0. The counter width covers 95556 (17 bits).
- Unit counter: 0..UNIT_CYCLES−1, plus a 4-bit remaining-units counter.

## Timing
- Reset values: state IDLE, addr 0, `buzzer_out` 0, `busy` 0, `done` 0, all counters 0.
- Reset asserted mid-note forces the reset values immediately (asynchronously).
- `start` sampled at edge k: `busy` = 1 from k+1 (LOAD); PLAY entered at edge k+2.
- For a non-rest note, `buzzer_out` goes to 1 on the PLAY-entry edge. It then toggles every H clocks.
- PLAY lasts exactly duration × UNIT_CYCLES clocks. GAP lasts exactly GAP_CYCLES clocks.
- Note-to-note period = 1 (LOAD) + dur × UNIT_CYCLES + GAP_CYCLES clocks.
- `buzzer_out` is forced to 0 on the edge that leaves PLAY, whatever the tone phase.
- `done` is high in the cycle after leaving GAP (last ROM entry) or after LOAD (end marker). `busy` falls one cycle after `done`.

## Structure
- Package `melody_pkg`:
  - pitch half-period table (localparam array);
  - note field widths;
  - state enum (IDLE, LOAD, PLAY, GAP, DONE);
  - end-marker constant.
- Sub-module `melody_rom`: parameters SONG_ID and SONG_LEN; synchronous read with 1-cycle latency; contents chosen by `case (SONG_ID)`; unused entries = 0x00 (end marker).
- The FSM and counters stay in `melody_player`.

## Test plan
All scenarios use UNIT_CYCLES=10, GAP_CYCLES=2, TONE_SHIFT=10.
1. ROM {0x62, 0x00} (A4, 2 units), pulse `start`:
   - PLAY lasts 20 cycles;
   - `buzzer_out` toggles every 55 cycles (56818>>10), so it is 1 throughout PLAY;
   - 2 gap cycles at 0;
   - `done` pulses once;
   - `busy` spans LOAD through DONE.
2. ROM {0x11, 0x01, 0x81, 0x00} with UNIT_CYCLES=300:
   - C4 half-period 93 cycles;
   - rest note keeps `buzzer_out`=0 for 300 cycles;
   - C5 half-period 46 cycles.
3. Assert `stop` during a PLAY of the second note: `buzzer_out`=0 and `busy`=0 on the next edge, no `done`. A subsequent `start` restarts from addr 0.
4. Pulse `start` again while `busy`: no effect on addr or timing. `start` and `stop` in the same IDLE cycle: the block stays in IDLE.
5. Deassert `reset_n` asynchronously mid-PLAY with `buzzer_out`=1: all outputs go to 0 immediately and stay at reset values until `start`.
6. ROM filled with SONG_LEN=4 non-zero notes and no marker: 4 notes are played, then `done` fires after the 4th gap, with no address wrap.
